sound_request_scheduler: RTL and testbench

Sits between game-logic requesters (per-player engines, CPU IO writes) and the sound generator's CPU write port. It arbitrates sound-effect requests round-robin, buffers them in a small FIFO, and issues one single-cycle write strobe per effect. Each issued effect is followed by a hold window so effects are not cut off. Priority codes (death sound) preempt everything queued or playing.

---
 rtl/sound_request_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_sound_request_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_request_scheduler.sv
// rtl/sound_request_scheduler.sv - round-robin sound effect scheduler with FIFO, hold window and priority preemption
//
// Purpose:
//   Arbitrates sound-effect requests from NUM_REQ requesters. Requesters carrying
//   PRIORITY_CODE win over all others. Within each class the grant is round-robin.
//   Accepted non-zero codes are queued in a FIFO. Each queued code is issued as one
//   single-cycle write strobe, and a hold window of HOLD_CYCLES follows each strobe.
//   A priority grant discards the queue and any hold in progress.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   req_valid      per-requester request, held until acked
//   req_code       requester i code in bits [i*CODE_W +: CODE_W]
//   req_ready      one-hot combinational ack, request consumed this cycle
//   flush          synchronous queue/timer clear, suppresses all acks this cycle
//   snd_write_en   one-cycle strobe to the sound generator
//   snd_write_data code being written, 0 when no strobe
//   busy           high while issuing or holding
//   fifo_count     number of queued entries
//   drop_count     (SOUND_SCHED_DROP_CNT_EN only) saturating count of discarded entries
//
// Optional feature macro: SOUND_SCHED_DROP_CNT_EN
module sound_request_scheduler #(
  parameter int                NUM_REQ       = 4,
  parameter int                CODE_W        = 2,
  parameter int                FIFO_DEPTH    = 4,
  parameter int                HOLD_CYCLES   = 1000000,
  parameter logic [CODE_W-1:0] PRIORITY_CODE = 2'b11
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*CODE_W-1:0]     req_code,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush,
  output logic                          snd_write_en,
  output logic [CODE_W-1:0]             snd_write_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef SOUND_SCHED_DROP_CNT_EN
  ,
  output logic [7:0]                    drop_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [RR_W-1:0]   r_rr;
  logic [TMR_W-1:0]  r_timer;
  logic [CODE_W-1:0] r_issue_code;

  logic [NUM_REQ-1:0] w_is_prio;
  logic               w_prio_hit;
  logic               w_norm_hit;
  logic [RR_W-1:0]    w_prio_idx;
  logic [RR_W-1:0]    w_norm_idx;
  logic [RR_W-1:0]    w_win_idx;
  logic [RR_W-1:0]    w_rr_next;
  logic [CODE_W-1:0]  w_win_code;
  logic               w_full;
  logic               w_grant_ok;
  logic               w_prio_take;
  logic               w_push;
  logic               w_pop;

  // Requester index at offset ofs from base, wrapping at NUM_REQ.
  function automatic logic [RR_W-1:0] rr_idx(input logic [RR_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return RR_W'(s);
  endfunction

  always_comb begin
    w_is_prio = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_is_prio[i] = req_valid[i] && (req_code[i*CODE_W +: CODE_W] == PRIORITY_CODE);
    end
  end

  // Two round-robin scans from the shared pointer: one over priority requesters,
  // one over all requesters. The priority scan result wins when it hits.
  always_comb begin
    w_prio_hit = 1'b0;
    w_norm_hit = 1'b0;
    w_prio_idx = '0;
    w_norm_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_prio_hit && w_is_prio[rr_idx(r_rr, k)]) begin
        w_prio_hit = 1'b1;
        w_prio_idx = rr_idx(r_rr, k);
      end
      if (!w_norm_hit && req_valid[rr_idx(r_rr, k)]) begin
        w_norm_hit = 1'b1;
        w_norm_idx = rr_idx(r_rr, k);
      end
    end
  end

  always_comb begin
    w_full      = (r_count == FULL_CNT);
    w_prio_take = w_prio_hit && !flush;
    w_grant_ok  = !flush && (w_prio_hit || (w_norm_hit && !w_full));
    w_win_idx   = w_prio_hit ? w_prio_idx : w_norm_idx;
    w_win_code  = req_code[int'(w_win_idx)*CODE_W +: CODE_W];
    w_rr_next   = (w_win_idx == RR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + RR_W'(1);
    // Code 0 is acked but never queued.
    w_push      = w_grant_ok && !w_prio_hit && (w_win_code != '0);
    // A priority grant rewrites the FIFO, so no pop that cycle.
    w_pop       = (r_state == S_IDLE) && (r_count != '0) && !flush && !w_prio_hit;
    req_ready   = (w_grant_ok && reset) ? (NUM_REQ'(1) << w_win_idx) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush || w_prio_take) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_pop) w_state_nxt = S_ISSUE;
        S_ISSUE: w_state_nxt = S_HOLD;
        S_HOLD:  if (r_timer == '0) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rr         <= '0;
      r_timer      <= '0;
      r_issue_code <= '0;
    end else begin
      if (w_grant_ok) r_rr <= w_rr_next;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_timer  <= '0;
      end else if (w_prio_take) begin
        // Priority code becomes the sole entry at slot 0.
        r_wr_ptr <= PTR_W'(1);
        r_rd_ptr <= '0;
        r_count  <= CNT_W'(1);
        r_timer  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop) begin
          r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
          r_issue_code <= r_mem[r_rd_ptr];
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (r_state == S_ISSUE) begin
          r_timer <= TMR_LOAD;
        end else if (r_state == S_HOLD && r_timer != '0) begin
          r_timer <= r_timer - TMR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (w_prio_take) begin
        r_mem[0] <= PRIORITY_CODE;
      end else if (w_push) begin
        r_mem[r_wr_ptr] <= w_win_code;
      end
    end
  end

`ifdef SOUND_SCHED_DROP_CNT_EN
  logic [7:0] r_drop;
  logic [8:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_drop} + 9'(r_count);

  // Only entries still queued are counted; a strobe already issued is not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop <= '0;
    end else if (flush || w_prio_take) begin
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign drop_count = r_drop;
`endif

  assign snd_write_en   = (r_state == S_ISSUE);
  assign snd_write_data = (r_state == S_ISSUE) ? r_issue_code : '0;
  assign busy           = (r_state != S_IDLE);
  assign fifo_count     = r_count;

endmodule

// File: tb/tb_sound_request_scheduler.sv
// tb/tb_sound_request_scheduler.sv - self-checking bench for sound_request_scheduler
module tb_sound_request_scheduler;

  localparam int N     = 4;
  localparam int CW    = 2;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*CW-1:0] req_code;
  logic [N-1:0]   req_ready;
  logic           flush;
  logic           snd_write_en;
  logic [CW-1:0]  snd_write_data;
  logic           busy;
  logic [2:0]     fifo_count;
`ifdef SOUND_SCHED_DROP_CNT_EN
  logic [7:0]     drop_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] v;
    logic [7:0] c;
    logic       f;
    logic [3:0] rdy;
    logic       we;
    logic [1:0] d;
    logic       bsy;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl [21];
  logic [3:0] exp_g [9];
  int s1, s2, n_strobe, n_busy;

  // reference model state: queue contents, RR pointer, timestamps
  int q [$];
  int m_rr, m_cyc, m_free, m_pop_cyc, m_pop_code, m_drop;

  sound_request_scheduler #(
    .NUM_REQ(N), .CODE_W(CW), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .PRIORITY_CODE(2'b11)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_code(req_code),
    .req_ready(req_ready),
    .flush(flush),
    .snd_write_en(snd_write_en),
    .snd_write_data(snd_write_data),
    .busy(busy),
    .fifo_count(fifo_count)
`ifdef SOUND_SCHED_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [3:0] v, input logic [7:0] c, input logic f);
    req_valid = v;
    req_code  = c;
    flush     = f;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_code  = 8'h55;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_we", int'(snd_write_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(fifo_count), 0);
    reset     = 1'b1;
    req_valid = '0;
    req_code  = '0;
  endtask

  task automatic row(input int i, input logic [3:0] v, input logic [7:0] c, input logic f,
                     input logic [3:0] r, input logic we, input logic [1:0] d,
                     input logic b, input logic [2:0] n);
    tbl[i] = '{v, c, f, r, we, d, b, n};
  endtask

  task automatic fill_table();
    row(0,  4'b0001, 8'h01, 0, 4'b0001, 0, 0, 0, 0);
    row(1,  4'b0000, 8'h00, 0, 4'b0000, 0, 0, 0, 1);
    row(2,  4'b0000, 8'h00, 0, 4'b0000, 1, 1, 1, 0);
    row(3,  4'b0000, 8'h00, 0, 4'b0000, 0, 0, 1, 0);
    row(4,  4'b0000, 8'h00, 0, 4'b0000, 0, 0, 1, 0);
    row(5,  4'b0000, 8'h00, 0, 4'b0000, 0, 0, 1, 0);
    row(6,  4'b0000, 8'h00, 0, 4'b0000, 0, 0, 1, 0);
    row(7,  4'b0000, 8'h00, 0, 4'b0000, 0, 0, 0, 0);
    row(8,  4'b0010, 8'h00, 0, 4'b0010, 0, 0, 0, 0);
    row(9,  4'b0000, 8'h00, 0, 4'b0000, 0, 0, 0, 0);
    row(10, 4'b0001, 8'h01, 0, 4'b0001, 0, 0, 0, 0);
    row(11, 4'b0010, 8'h08, 0, 4'b0010, 0, 0, 0, 1);
    row(12, 4'b0100, 8'h10, 0, 4'b0100, 1, 1, 1, 1);
    row(13, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 1, 2);
    for (int i = 14; i < 21; i++) row(i, 4'b0000, 8'h00, 0, 4'b0000, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    q.delete();
    m_rr = 0; m_cyc = 0; m_free = 0; m_pop_cyc = -100; m_pop_code = 0; m_drop = 0;
  endtask

  task automatic run_random(input int ncyc);
    logic [3:0] v;
    logic [7:0] c;
    logic       f;
    logic [3:0] er;
    int win, isp, ew, ed, eb, idx, cd, r;
    model_reset();
    v = '0; c = '0; f = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      apply(v, c, f);
      win = -1; isp = 0;
      if (!f) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (win < 0 && v[idx] && c[idx*CW +: CW] == 2'b11) begin win = idx; isp = 1; end
        end
        if (win < 0 && q.size() < DEPTH) begin
          for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (win < 0 && v[idx]) win = idx;
          end
        end
      end
      er = (win < 0) ? 4'b0000 : 4'(1 << win);
      ew = (m_cyc == m_pop_cyc + 1) ? 1 : 0;
      ed = (ew != 0) ? m_pop_code : 0;
      eb = (m_cyc < m_free) ? 1 : 0;
      chk("rnd_ready", int'(req_ready), int'(er));
      chk("rnd_we", int'(snd_write_en), ew);
      chk("rnd_data", int'(snd_write_data), ed);
      chk("rnd_busy", int'(busy), eb);
      chk("rnd_count", int'(fifo_count), q.size());
`ifdef SOUND_SCHED_DROP_CNT_EN
      chk("rnd_drop", int'(drop_count), m_drop);
`endif
      if (f) begin
        m_drop = (m_drop + q.size() > 255) ? 255 : m_drop + q.size();
        q.delete();
        m_free = m_cyc + 1;
      end else if (isp != 0) begin
        m_drop = (m_drop + q.size() > 255) ? 255 : m_drop + q.size();
        q.delete();
        q.push_back(3);
        m_free = m_cyc + 1;
      end else begin
        if (m_cyc >= m_free && q.size() > 0) begin
          m_pop_code = q.pop_front();
          m_pop_cyc  = m_cyc;
          m_free     = m_cyc + HOLD + 2;
        end
        if (win >= 0 && c[win*CW +: CW] != 2'b00) q.push_back(int'(c[win*CW +: CW]));
      end
      if (win >= 0) m_rr = (win + 1) % N;
      m_cyc++;
      for (int i = 0; i < N; i++) begin
        if (v[i] && er[i]) v[i] = 1'b0;
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          r  = $urandom_range(0, 11);
          cd = (r == 0) ? 0 : (r == 11) ? 3 : (r < 6) ? 1 : 2;
          v[i] = 1'b1;
          c[i*CW +: CW] = 2'(cd);
        end
      end
      f = ($urandom_range(0, 39) == 0);
      tick();
    end
  endtask

  initial begin
    fill_table();
    do_reset();

    // directed table: single request, code 0, flush with two queued
    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].v, tbl[i].c, tbl[i].f);
      chk($sformatf("tbl%0d_ready", i), int'(req_ready), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_we", i), int'(snd_write_en), int'(tbl[i].we));
      chk($sformatf("tbl%0d_data", i), int'(snd_write_data), int'(tbl[i].d));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].bsy));
      chk($sformatf("tbl%0d_count", i), int'(fifo_count), int'(tbl[i].cnt));
      tick();
    end
`ifdef SOUND_SCHED_DROP_CNT_EN
    chk("flush_drop", int'(drop_count), 2);
`endif

    // round-robin with all requesters continuously valid until FIFO fills
    do_reset();
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    s1 = -1; s2 = -1;
    for (int c = 0; c < 9; c++) begin
      apply(4'b1111, 8'h55, 1'b0);
      chk($sformatf("rr_grant%0d", c), int'(req_ready), int'(exp_g[c]));
      if (c == 5) chk("rr_full_count", int'(fifo_count), 4);
      if (snd_write_en) begin
        if (s1 < 0) s1 = c;
        else if (s2 < 0) s2 = c;
      end
      tick();
    end
    chk("rr_strobe_spacing", s2 - s1, HOLD + 2);

    // priority preemption with three queued entries during hold
    do_reset();
    apply(4'b0001, 8'h01, 1'b0); chk("pq_ack0", int'(req_ready), 1); tick();
    apply(4'b0010, 8'h04, 1'b0); chk("pq_ack1", int'(req_ready), 2); tick();
    apply(4'b0100, 8'h10, 1'b0); chk("pq_ack2", int'(req_ready), 4);
    chk("pq_first_strobe", int'(snd_write_en), 1); tick();
    apply(4'b1000, 8'h40, 1'b0); chk("pq_ack3", int'(req_ready), 8); tick();
    apply(4'b0100, 8'h30, 1'b0); chk("prio_ack", int'(req_ready), 4);
    chk("prio_pre_count", int'(fifo_count), 3);
    chk("prio_pre_busy", int'(busy), 1); tick();
    apply(4'b0000, 8'h00, 1'b0); chk("prio_count", int'(fifo_count), 1);
    chk("prio_no_early_strobe", int'(snd_write_en), 0);
`ifdef SOUND_SCHED_DROP_CNT_EN
    chk("prio_drop", int'(drop_count), 3);
`endif
    tick();
    apply(4'b0000, 8'h00, 1'b0); chk("prio_strobe_en", int'(snd_write_en), 1);
    chk("prio_strobe_data", int'(snd_write_data), 3); tick();
    n_strobe = 0;
    for (int c = 0; c < 14; c++) begin
      apply(4'b0000, 8'h00, 1'b0);
      if (snd_write_en) n_strobe++;
      tick();
    end
    chk("prio_no_stale_strobe", n_strobe, 0);

    // flush beats a simultaneous priority request
    apply(4'b0100, 8'h30, 1'b1); chk("flush_beats_prio", int'(req_ready), 0); tick();
    apply(4'b0100, 8'h30, 1'b0); chk("prio_after_flush", int'(req_ready), 4); tick();
    apply(4'b0001, 8'h01, 1'b0); chk("fp_ack", int'(req_ready), 1);
    chk("fp_count", int'(fifo_count), 1); tick();
    apply(4'b0000, 8'h00, 1'b0); chk("fp_strobe", int'(snd_write_en), 1);
    chk("fp_data", int'(snd_write_data), 3);
    chk("fp_queued", int'(fifo_count), 1); tick();

    // asynchronous reset in the middle of a hold with one entry queued
    reset     = 1'b0;
    req_valid = 4'b0100;
    req_code  = 8'h10;
    #1;
    chk("hold_rst_ready", int'(req_ready), 0);
    chk("hold_rst_we", int'(snd_write_en), 0);
    chk("hold_rst_data", int'(snd_write_data), 0);
    chk("hold_rst_busy", int'(busy), 0);
    chk("hold_rst_count", int'(fifo_count), 0);
`ifdef SOUND_SCHED_DROP_CNT_EN
    chk("hold_rst_drop", int'(drop_count), 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    n_strobe = 0; n_busy = 0;
    for (int c = 0; c < 10; c++) begin
      apply(4'b0000, 8'h00, 1'b0);
      if (snd_write_en) n_strobe++;
      if (busy) n_busy++;
      tick();
    end
    chk("post_rst_strobes", n_strobe, 0);
    chk("post_rst_busy", n_busy, 0);

    // randomized traffic against the reference model
    do_reset();
    run_random(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
